// File: rtl/mem_ctrl_p.sv
// Parametrised single-port memory behind a valid/ready request channel and a
// valid/ready read-response channel, with configurable read latency and range checking.
module mem_ctrl_p #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat transfers on a rising edge where valid && ready. req_ready
  // and rsp_valid are pure state decodes, so neither depends on the opposite side.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0]  CNT_LOAD = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;
  localparam logic [16:0] DEPTH_L  = 17'(DEPTH);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              wr_en;
  logic              in_range;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign in_range = ({{(17-ADDR_W){1'b0}}, req_addr} < DEPTH_L);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_rw) begin
            // Read data is captured at acceptance; no write can slip in before it is consumed.
            rdata_d = in_range ? mem_q[req_addr] : '0;
            err_d   = !in_range;
            if (READ_LATENCY == 1) begin
              state_d = RESP;
            end else begin
              state_d = WAIT;
              cnt_d   = CNT_LOAD;
            end
          end else begin
            wr_en = in_range;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive RST.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[req_addr] <= req_wdata;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q == WAIT) || (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid && err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_ctrl_p.sv
// Directed bench for mem_ctrl_p: one default instance (8x256, latency 1) and one
// 16-bit, 200-word, latency-3 instance, driven through shared tasks.
module tb_mem_ctrl_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rw;
  logic [7:0]  addr;
  logic [15:0] wdata;

  logic        v0, rr0, rdy0, rv0, err0, busy0;
  logic [7:0]  rd0;
  logic [1:0]  st0;
  logic        v1, rr1, rdy1, rv1, err1, busy1;
  logic [15:0] rd1;
  logic [1:0]  st1;

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;

  logic        c_rdy, c_rv, c_err, c_busy;
  logic [15:0] c_rd;
  logic [1:0]  c_st;

  always #5 clk = ~clk;

  mem_ctrl_p u0 (
    .CLK(clk), .RST(rst_n), .req_valid(v0), .req_ready(rdy0), .req_rw(rw),
    .req_addr(addr), .req_wdata(wdata[7:0]), .rsp_valid(rv0), .rsp_ready(rr0),
    .rsp_rdata(rd0), .rsp_err(err0), .busy(busy0), .dbg_state(st0)
  );

  mem_ctrl_p #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .READ_LATENCY(3)) u1 (
    .CLK(clk), .RST(rst_n), .req_valid(v1), .req_ready(rdy1), .req_rw(rw),
    .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv1), .rsp_ready(rr1),
    .rsp_rdata(rd1), .rsp_err(err1), .busy(busy1), .dbg_state(st1)
  );

  always_comb begin
    c_rdy  = rdy0;
    c_rv   = rv0;
    c_err  = err0;
    c_busy = busy0;
    c_rd   = {8'h00, rd0};
    c_st   = st0;
    if (sel == 1) begin
      c_rdy  = rdy1;
      c_rv   = rv1;
      c_err  = err1;
      c_busy = busy1;
      c_rd   = rd1;
      c_st   = st1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (u%0d): got 0x%0h, expected 0x%0h at %0t", tag, sel, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input logic b);
    if (sel == 0) v0 = b;
    else          v1 = b;
  endtask

  task automatic set_rr(input logic b);
    if (sel == 0) rr0 = b;
    else          rr1 = b;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rdy"},  32'(c_rdy),  32'd1);
    check_eq({tag, "_rv"},   32'(c_rv),   32'd0);
    check_eq({tag, "_busy"}, 32'(c_busy), 32'd0);
    check_eq({tag, "_rd"},   32'(c_rd),   32'd0);
    check_eq({tag, "_err"},  32'(c_err),  32'd0);
  endtask

  task automatic do_write(input int s, input logic [7:0] a, input logic [15:0] d);
    sel   = s;
    rw    = 1'b0;
    addr  = a;
    wdata = d;
    set_valid(1'b1);
    #0;
    check_eq("wr_rdy", 32'(c_rdy), 32'd1);
    tick();
    set_valid(1'b0);
  endtask

  task automatic do_read(input int s, input logic [7:0] a, input logic [15:0] exp_d,
                         input logic exp_e, input int lat, input int bp, input bit pulse);
    int waited;
    sel  = s;
    rw   = 1'b1;
    addr = a;
    set_valid(1'b1);
    #0;
    check_eq("rd_rdy", 32'(c_rdy), 32'd1);
    tick();
    set_valid(1'b0);
    set_rr(bp == 0);
    waited = 0;
    while (!c_rv && waited < 8) begin
      check_eq("wait_busy", 32'(c_busy), 32'd1);
      check_eq("wait_nordy", 32'(c_rdy), 32'd0);
      check_eq("wait_rd0", 32'(c_rd), 32'd0);
      if (pulse) begin
        rw    = 1'b0;
        wdata = 16'h1234;
        set_valid(1'b1);
      end
      tick();
      waited++;
    end
    set_valid(1'b0);
    check_eq("rd_latency", 32'(waited), 32'(lat - 1));
    check_eq("rd_valid", 32'(c_rv), 32'd1);
    check_eq("rd_data", 32'(c_rd), 32'(exp_d));
    check_eq("rd_err", 32'(c_err), 32'(exp_e));
    check_eq("rsp_nordy", 32'(c_rdy), 32'd0);
    check_eq("rsp_busy", 32'(c_busy), 32'd1);
    for (int k = 0; k < bp; k++) begin
      tick();
      check_eq("bp_valid", 32'(c_rv), 32'd1);
      check_eq("bp_data", 32'(c_rd), 32'(exp_d));
      check_eq("bp_err", 32'(c_err), 32'(exp_e));
      check_eq("bp_nordy", 32'(c_rdy), 32'd0);
    end
    set_rr(1'b1);
    tick();
    check_idle_outputs("consumed");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rw    = 1'b0;
    addr  = '0;
    wdata = '0;
    v0    = 1'b0;
    v1    = 1'b0;
    rr0   = 1'b1;
    rr1   = 1'b1;

    // Reset state before any clock edge.
    #2;
    sel = 0; #0;
    check_idle_outputs("reset_u0");
    check_eq("reset_st", 32'(c_st), 32'd0);
    sel = 1; #0;
    check_idle_outputs("reset_u1");
    tick();
    tick();
    #3 rst_n = 1'b1;

    // Default instance: write then read, read-after-write, back-to-back writes.
    do_write(0, 8'h10, 16'h00A5);
    do_read(0, 8'h10, 16'h00A5, 1'b0, 1, 0, 1'b0);
    do_write(0, 8'h00, 16'h0011);
    do_write(0, 8'h01, 16'h0022);
    do_write(0, 8'h02, 16'h0033);
    do_write(0, 8'h03, 16'h0044);
    do_read(0, 8'h03, 16'h0044, 1'b0, 1, 0, 1'b0);
    do_read(0, 8'h00, 16'h0011, 1'b0, 1, 0, 1'b0);
    do_write(0, 8'hFF, 16'h007E);
    do_read(0, 8'hFF, 16'h007E, 1'b0, 1, 0, 1'b0);
    do_read(0, 8'h01, 16'h0022, 1'b0, 1, 2, 1'b0);

    // Latency-3 instance: req_valid pulses during WAIT must be ignored.
    do_write(1, 8'h07, 16'hBEEF);
    do_read(1, 8'h07, 16'hBEEF, 1'b0, 3, 0, 1'b1);
    do_read(1, 8'h07, 16'hBEEF, 1'b0, 3, 0, 1'b0);

    // Back-pressure for five cycles, then range boundary checks.
    do_write(1, 8'd199, 16'h0C0D);
    do_read(1, 8'd199, 16'h0C0D, 1'b0, 3, 5, 1'b0);
    do_write(1, 8'd250, 16'h0055);
    do_read(1, 8'd250, 16'h0000, 1'b1, 3, 0, 1'b0);
    do_read(1, 8'd200, 16'h0000, 1'b1, 3, 0, 1'b0);
    do_read(1, 8'd199, 16'h0C0D, 1'b0, 3, 0, 1'b0);

    // Reset while a read sits in WAIT: response must be dropped, memory kept.
    do_write(1, 8'h05, 16'h3C3C);
    sel  = 1;
    rw   = 1'b1;
    addr = 8'h05;
    v1   = 1'b1;
    tick();
    v1 = 1'b0;
    check_eq("mid_wait_busy", 32'(c_busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    check_eq("mid_reset_st", 32'(c_st), 32'd0);
    tick();
    #3 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("no_rsp_after_reset", 32'(c_rv), 32'd0);
    end
    do_read(1, 8'h05, 16'h3C3C, 1'b0, 3, 0, 1'b0);
    do_read(1, 8'h07, 16'hBEEF, 1'b0, 3, 0, 1'b0);
    do_read(0, 8'h10, 16'h00A5, 1'b0, 1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
